// File: rtl/shiftreg_pkg.sv
// Shared mode encoding for the SPI datapath shift register.
// The optional bit counter is enabled with SHIFTREG_BITCNT_EN.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    PLOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/shift_register8_if.sv
// Data/control bundle of shift_register8. The master drives the controls and the slave returns register state.
// Handshake: none. serialClkposedge is a level-qualified per-clk enable, and inputs are sampled only on cycles where it is high.
// SHIFTREG_BITCNT_EN adds bitCount/byteDone.
interface shift_register8_if #(parameter int width = 8);
  import shiftreg_pkg::*;

  logic             serialClkposedge;
  mode_t            mode;
  logic [width-1:0] parallelIn;
  logic             serialIn;
  logic [width-1:0] parallelOut;
  logic             serialOut;

`ifdef SHIFTREG_BITCNT_EN
  logic [$clog2(width+1)-1:0] bitCount;
  logic                       byteDone;

  modport master (
    output serialClkposedge, mode, parallelIn, serialIn,
    input  parallelOut, serialOut, bitCount, byteDone
  );
  modport slave (
    input  serialClkposedge, mode, parallelIn, serialIn,
    output parallelOut, serialOut, bitCount, byteDone
  );
`else
  modport master (
    output serialClkposedge, mode, parallelIn, serialIn,
    input  parallelOut, serialOut
  );
  modport slave (
    input  serialClkposedge, mode, parallelIn, serialIn,
    output parallelOut, serialOut
  );
`endif

endinterface

// File: rtl/shiftreg_bitcnt.sv
// Optional shift counter, instantiated only when SHIFTREG_BITCNT_EN is defined.
// Counts qualified shifts modulo width and pulses byteDone on the cycle after the wrap.
module shiftreg_bitcnt
  import shiftreg_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  mode_t                      mode,
  output logic [$clog2(width+1)-1:0] bitCount,
  output logic                       byteDone
);

  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitCount <= '0;
      byteDone <= 1'b0;
    end else begin
      // byteDone is a single-cycle pulse, so it drops on every cycle that does not wrap.
      byteDone <= 1'b0;
      if (enable) begin
        case (mode)
          PLOAD: bitCount <= '0;
          LEFT, RIGHT: begin
            if (bitCount == LAST) begin
              bitCount <= '0;
              byteDone <= 1'b1;
            end else begin
              bitCount <= bitCount + CW'(1);
            end
          end
          default: bitCount <= bitCount;
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_register8.sv
// PIPO/SISO shift register for the SPI datapath. It advances only on serial-clock rising-edge strobes.
// Define SHIFTREG_BITCNT_EN to add the bitCount/byteDone counter.
module shift_register8
  import shiftreg_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_register8_if.slave bus
);

  logic [width-1:0] shiftreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftreg <= '0;
    end else if (bus.serialClkposedge) begin
      case (bus.mode)
        LEFT:    shiftreg <= {shiftreg[width-2:0], bus.serialIn};
        RIGHT:   shiftreg <= {bus.serialIn, shiftreg[width-1:1]};
        PLOAD:   shiftreg <= bus.parallelIn;
        default: shiftreg <= shiftreg;
      endcase
    end
  end

  // serialOut is always the MSB. In RIGHT mode it therefore echoes the bit just shifted in.
  assign bus.parallelOut = shiftreg;
  assign bus.serialOut   = shiftreg[width-1];

`ifdef SHIFTREG_BITCNT_EN
  shiftreg_bitcnt #(.width(width)) u_bitcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (bus.serialClkposedge),
    .mode     (bus.mode),
    .bitCount (bus.bitCount),
    .byteDone (bus.byteDone)
  );
`endif

endmodule

// File: tb/tb_shift_register8.sv
// Bench for shift_register8 that applies a vector table, reset, and counter sequences.
// It also exercises SHIFTREG_BITCNT_EN when that macro is defined.
module tb_shift_register8;
  import shiftreg_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [W:0] exp_q[$];

  shift_register8_if #(.width(W)) bus ();

  shift_register8 #(.width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired before summary");
    $fatal(1);
  end

  typedef struct {
    logic       stb;
    mode_t      mode;
    logic [7:0] pin;
    logic       sin;
    logic [7:0] expPar;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver + scoreboard: push expectation on drive, pop after the edge
  task automatic step(input logic stb, input mode_t m, input logic [7:0] pin,
                      input logic sin, input logic [7:0] expPar);
    logic [W:0] e;
    @(negedge clk);
    bus.serialClkposedge = stb;
    bus.mode             = m;
    bus.parallelIn       = pin;
    bus.serialIn         = sin;
    exp_q.push_back({expPar[7], expPar});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("parallelOut", 32'(bus.parallelOut), 32'(e[W-1:0]));
    check("serialOut", 32'(bus.serialOut), 32'(e[W]));
  endtask

  function automatic vec_t mk(input logic stb, input mode_t m, input logic [7:0] pin,
                              input logic sin, input logic [7:0] expPar);
    vec_t v;
    v.stb = stb; v.mode = m; v.pin = pin; v.sin = sin; v.expPar = expPar;
    return v;
  endfunction

  initial begin
    logic [7:0] r;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.serialClkposedge = 1'b0;
    bus.mode             = HOLD;
    bus.parallelIn       = '0;
    bus.serialIn         = 1'b0;

    // parallel load, gated load, hold
    vecs[0]  = mk(1, PLOAD, 8'h00, 0, 8'h00);
    vecs[1]  = mk(1, PLOAD, 8'h7F, 0, 8'h7F);
    vecs[2]  = mk(1, PLOAD, 8'h77, 0, 8'h77);
    vecs[3]  = mk(0, PLOAD, 8'hAA, 0, 8'h77);
    vecs[4]  = mk(1, PLOAD, 8'h7F, 0, 8'h7F);
    vecs[5]  = mk(1, HOLD,  8'h78, 1, 8'h7F);
    vecs[6]  = mk(1, HOLD,  8'h2C, 1, 8'h7F);
    vecs[7]  = mk(1, HOLD,  8'h78, 1, 8'h7F);
    // left shift from 8'h04
    vecs[8]  = mk(1, PLOAD, 8'h04, 0, 8'h04);
    vecs[9]  = mk(1, LEFT,  8'hFF, 0, 8'h08);
    vecs[10] = mk(1, LEFT,  8'hFF, 0, 8'h10);
    vecs[11] = mk(1, LEFT,  8'hFF, 1, 8'h21);
    vecs[12] = mk(1, LEFT,  8'hFF, 1, 8'h43);
    vecs[13] = mk(1, LEFT,  8'hFF, 1, 8'h87);
    vecs[14] = mk(1, LEFT,  8'hFF, 1, 8'h0F);
    // right shift from 0
    vecs[15] = mk(1, PLOAD, 8'h00, 0, 8'h00);
    vecs[16] = mk(1, RIGHT, 8'hFF, 1, 8'h80);
    vecs[17] = mk(1, RIGHT, 8'hFF, 1, 8'hC0);
    vecs[18] = mk(1, RIGHT, 8'hFF, 0, 8'h60);
    vecs[19] = mk(1, RIGHT, 8'hFF, 1, 8'hB0);
    vecs[20] = mk(1, RIGHT, 8'hFF, 0, 8'h58);
    vecs[21] = mk(1, RIGHT, 8'hFF, 1, 8'hAC);
    vecs[22] = mk(1, RIGHT, 8'hFF, 0, 8'h56);
    vecs[23] = mk(1, RIGHT, 8'hFF, 0, 8'h2B);
    // strobe low freezes shifts too
    vecs[24] = mk(0, LEFT,  8'hFF, 1, 8'h2B);
    vecs[25] = mk(0, RIGHT, 8'hFF, 1, 8'h2B);

    repeat (2) @(posedge clk);
    #1;
    check("reset parallelOut", 32'(bus.parallelOut), 32'h0);
    check("reset serialOut", 32'(bus.serialOut), 32'h0);
`ifdef SHIFTREG_BITCNT_EN
    check("reset bitCount", 32'(bus.bitCount), 32'h0);
    check("reset byteDone", 32'(bus.byteDone), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++)
      step(vecs[i].stb, vecs[i].mode, vecs[i].pin, vecs[i].sin, vecs[i].expPar);

    // random parallel loads
    for (int i = 0; i < 6; i++) begin
      r = 8'($urandom_range(0, 255));
      step(1, PLOAD, r, 1'($urandom_range(0, 1)), r);
    end

    // asynchronous reset mid-cycle beats a pending load
    step(1, PLOAD, 8'hFF, 0, 8'hFF);
    @(negedge clk);
    bus.serialClkposedge = 1'b1;
    bus.mode             = PLOAD;
    bus.parallelIn       = 8'hFF;
    rst_n = 1'b0;
    #1;
    check("async reset parallelOut", 32'(bus.parallelOut), 32'h0);
    check("async reset serialOut", 32'(bus.serialOut), 32'h0);
    @(posedge clk);
    #1;
    check("reset held parallelOut", 32'(bus.parallelOut), 32'h0);
    @(negedge clk);
    bus.serialClkposedge = 1'b0;
    rst_n = 1'b1;
    step(1, LEFT, 8'h00, 1, 8'h01);

`ifdef SHIFTREG_BITCNT_EN
    step(1, PLOAD, 8'h00, 0, 8'h00);
    check("load bitCount", 32'(bus.bitCount), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step(1, LEFT, 8'h00, 1, 8'hFF >> (8 - i));
      check("shift bitCount", 32'(bus.bitCount), 32'(i % 8));
      check("shift byteDone", 32'(bus.byteDone), 32'(i == 8));
    end
    step(1, HOLD, 8'h00, 0, 8'hFF);
    check("post byteDone", 32'(bus.byteDone), 32'h0);
    check("hold bitCount", 32'(bus.bitCount), 32'h0);
    step(1, LEFT, 8'h00, 0, 8'hFE);
    step(1, LEFT, 8'h00, 0, 8'hFC);
    step(0, LEFT, 8'h00, 0, 8'hFC);
    step(1, LEFT, 8'h00, 0, 8'hF8);
    check("mid bitCount", 32'(bus.bitCount), 32'h3);
    step(1, PLOAD, 8'h5A, 0, 8'h5A);
    check("pload clears bitCount", 32'(bus.bitCount), 32'h0);
    check("pload byteDone", 32'(bus.byteDone), 32'h0);
`endif

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: got %0d leftover want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_register8.md
Name: shift_register8

Overview:
- Parameterised parallel-in/parallel-out, serial-in/serial-out shift register for the SPI datapath.
- Runs on the system clock and advances only on cycles where the serial-clock rising-edge strobe is high.
- Four modes: hold, shift left (MSB-first), shift right, and parallel load.
- Serial output is always the register MSB.

Parameters:
- width, 8, register width in bits (≥2).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- serialClkposedge  input  1  update enable: single-cycle strobe marking a serial-clock rising edge. Held high = update every clk.
- mode  input  2  operation select: HOLD=2'b00, LEFT=2'b01, RIGHT=2'b10, PLOAD=2'b11.
- parallelIn  input  width  data loaded in PLOAD.
- serialIn  input  1  bit shifted in during LEFT/RIGHT.
- parallelOut  output  width  current register contents.
- serialOut  output  1  always parallelOut[width-1].

Behaviour:
- Register, internally named shiftreg[width-1:0], drives parallelOut directly (no extra output stage).
- rst_n low: shiftreg cleared to 0 immediately, without waiting for clk.
  - parallelOut=0, serialOut=0, optional counter=0, optional done=0.
- Reset priority: reset beats every other input, including mid-shift.
- Posedge clk with rst_n high and serialClkposedge=1:
  - HOLD: shiftreg unchanged.
  - LEFT: shiftreg <= {shiftreg[width-2:0], serialIn}.
  - RIGHT: shiftreg <= {serialIn, shiftreg[width-1:1]}.
  - PLOAD: shiftreg <= parallelIn.
- Posedge clk with serialClkposedge=0: shiftreg unchanged in every mode.
- Latency: one clk from the qualifying edge to parallelOut/serialOut. serialOut is combinational from shiftreg[width-1].
- LEFT: MSB is shifted out through serialOut; serialIn enters at the LSB.
- RIGHT: serialIn enters at the MSB, so serialOut shows the bit just shifted in; the LSB is discarded.
- mode, parallelIn, serialIn are sampled only at the qualifying edge; changes between edges have no effect.
- No handshake and no internal edge detection: the enable is level-qualified per clk cycle.

Optional Feature:
- Macro SHIFTREG_BITCNT_EN.
- Defined, adds two outputs:
  - bitCount [$clog2(width+1)-1:0].
  - byteDone [1].
- bitCount:
  - reset to 0 by rst_n or by a qualifying PLOAD;
  - increments on each qualifying LEFT/RIGHT;
  - on reaching width it wraps to 0.
- byteDone: registered, high for exactly the one clk cycle following the shift that wrapped bitCount.
- HOLD and non-qualified cycles leave both untouched.
- Not defined: ports and logic absent; core behaviour identical.

Decomposition:
- Package shiftreg_pkg holds the mode constants HOLD/LEFT/RIGHT/PLOAD and a mode typedef (2-bit enum).
- One sub-module, shiftreg_bitcnt: the optional counter, instantiated only under SHIFTREG_BITCNT_EN.
- Core register logic stays in the top module.

Test Plan:
- Reset: drive rst_n low mid-cycle after loading 8'hFF -> parallelOut=0, serialOut=0 immediately, before the next clk.
- Parallel load: PLOAD with strobe, in turn, with parallelIn=0, then 8'h7F, then 8'h77 -> parallelOut equals each value one clk later; with strobe=0, a PLOAD of 8'hAA leaves the register unchanged.
- Hold: load 8'h7F, switch to HOLD, pulse strobe 3× with serialIn=1 and parallelIn=8'h78/8'h2C -> parallelOut stays 8'h7F.
- Left: load 8'h04, strobe held high in LEFT, serialIn 0,0,1,1,1,1 -> parallelOut 08,10,21,43,87,0F; serialOut 0,0,0,0,1,0.
- Right: load 0, strobe high in RIGHT, serialIn 1,1,0,1,0,1,0,0 -> serialOut tracks each serialIn; final parallelOut=8'b00101011.
- Bit counter (SHIFTREG_BITCNT_EN): load, then 8 qualifying LEFT shifts -> bitCount 1..7 then 0; byteDone high one cycle after the 8th shift; a PLOAD mid-count returns bitCount to 0.
